pipeline_hazard_ctrl: RTL

//  Hazard/sequencing controller for the 5-stage RV32 pipeline registers (F/D, D/E, E/M, M/W).
//  - Generates stall/flush enables for the pipeline registers.
//  - Generates operand-forwarding selects for the Execute stage.
//  - Sequences multi-cycle Execute ops (MUL/DIV): holds F/D/E and injects bubbles into M until done.
//  - Keeps a saturating count of stall cycles for debug.

---
 rtl/pipeline_defs.sv | 32 +++
 rtl/mdiv_seq.sv | 68 ++++++
 rtl/pipeline_hazard_ctrl.sv | 74 +++++++
 3 files changed

// File: rtl/pipeline_defs.sv
// Shared definitions for the RV32 pipeline hazard controller.
// Forwarding selects, multi-cycle sequencer states, select helper.
package pipeline_defs;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdiv_state_t;

    // Memory-stage result is younger, so it wins over Writeback.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rdm,
        input logic       rwm,
        input logic [4:0] rdw,
        input logic       rww
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (rwm && (rdm != 5'd0) && (rs == rdm))
            sel = FWD_MEM;
        else if (rww && (rdw != 5'd0) && (rs == rdw))
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/mdiv_seq.sv
// Multi-cycle Execute sequencer for MUL/DIV ops.
// Holds the op in Execute for MDIV_LAT cycles, stalling all but the last.
module mdiv_seq
    import pipeline_defs::*;
#(
    parameter int MDIV_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic MultiCycleE,
    output logic mdivStall,
    output logic MdivDoneE
);

    localparam int CW = (MDIV_LAT > 2) ? $clog2(MDIV_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MDIV_LAT - 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    mdiv_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    // State and remaining-cycle counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state, counter and stall/done decode.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        mdivStall = 1'b0;
        MdivDoneE = 1'b0;
        case (state)
            IDLE: begin
                if (MultiCycleE) begin
                    mdivStall = 1'b1;
                    if (MDIV_LAT == 2) begin
                        state_n = DONE;
                    end else begin
                        state_n = BUSY;
                        cnt_n   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                mdivStall = 1'b1;
                if (cnt == CNT_ONE)
                    state_n = DONE;
                else
                    cnt_n = cnt - CNT_ONE;
            end
            DONE: begin
                MdivDoneE = 1'b1;
                state_n   = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline.
// Stall/flush enables, Execute forwarding, MDIV sequencing, stall counter.
module pipeline_hazard_ctrl
    import pipeline_defs::*;
#(
    parameter int MDIV_LAT = 4,
    parameter int CNTW     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      Rs1E,
    input  logic [4:0]      Rs2E,
    input  logic [4:0]      RdE,
    input  logic [4:0]      RdM,
    input  logic [4:0]      RdW,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    input  logic            LoadE,
    input  logic            PCSrcE,
    input  logic            MultiCycleE,
    output logic            StallF,
    output logic            StallD,
    output logic            StallE,
    output logic            FlushD,
    output logic            FlushE,
    output logic            FlushM,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic            MdivDoneE,
    output logic [CNTW-1:0] StallCnt
);

    logic lwStall;
    logic mdivStall;

    mdiv_seq #(
        .MDIV_LAT(MDIV_LAT)
    ) u_mdiv (
        .clk        (clk),
        .reset      (reset),
        .MultiCycleE(MultiCycleE),
        .mdivStall  (mdivStall),
        .MdivDoneE  (MdivDoneE)
    );

    // Operand forwarding and load-use detection.
    always_comb begin
        ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
        lwStall   = LoadE && (RdE != 5'd0) &&
                    ((Rs1D == RdE) || (Rs2D == RdE));
    end

    // Stall and flush enables; a held MDIV op must not be flushed from E.
    always_comb begin
        StallF = lwStall | mdivStall;
        StallD = lwStall | mdivStall;
        StallE = mdivStall;
        FlushD = PCSrcE;
        FlushE = (lwStall | PCSrcE) & ~mdivStall;
        FlushM = mdivStall;
    end

    // Saturating count of fetch-stall cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            StallCnt <= '0;
        else if (StallF && (StallCnt != {CNTW{1'b1}}))
            StallCnt <= StallCnt + CNTW'(1);
    end

endmodule
